// File: rtl/bcd_count.sv
// bcd_count: cascadable multi-digit BCD up-counter with enable and terminal count
module bcd_count #(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  tc
);
  logic [DIGITS:0]     c;
  logic [4*DIGITS-1:0] nq;
  // c[k] means digit k steps this edge; an illegal digit (>9) loads 0 and, not being 9, never carries
  always_comb begin
    c[0] = enable;
    nq = Q;
    for (int k = 0; k < DIGITS; k++) begin
      nq[4*k +: 4] = !c[k] ? Q[4*k +: 4] : (Q[4*k +: 4] >= 4'd9) ? 4'd0 : Q[4*k +: 4] + 4'd1;
      c[k+1] = c[k] && (Q[4*k +: 4] == 4'd9);
    end
  end
  assign tc = c[DIGITS];
  always_ff @(posedge clk or posedge reset)
    if (reset) Q <= '0;
    else Q <= nq;
endmodule

// File: tb/tb_bcd_count.sv
// tb_bcd_count: randomized self-checking bench for one- and two-digit bcd_count against a decimal model
module tb_bcd_count;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en1 = 1'b0;
  logic en2 = 1'b0;
  logic [3:0] q1;
  logic [7:0] q2;
  logic tc1, tc2;
  int checks = 0;
  int failures = 0;
  int m1 = 0;
  int m2 = 0;

  always #5 clk = ~clk;

  bcd_count dut1 (.clk(clk), .reset(reset), .enable(en1), .Q(q1), .tc(tc1));
  bcd_count #(.DIGITS(2)) dut2 (.clk(clk), .reset(reset), .enable(en2), .Q(q2), .tc(tc2));

  function automatic logic [7:0] bcd2(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic step();
    if (!reset && en1) m1 = (m1 + 1) % 10;
    if (!reset && en2) m2 = (m2 + 1) % 100;
    if (reset) begin m1 = 0; m2 = 0; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en1 = 1'b1; en2 = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (q1 !== 4'd0 || tc1 !== 1'b0 || q2 !== 8'h00 || tc2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: q1=%h tc1=%b q2=%h tc2=%b want 0 0 00 0", q1, tc1, q2, tc2);
      end
    end
    reset = 1'b0; en2 = 1'b0;
    repeat (7) step();
    checks++;
    if (q1 !== 4'd7) begin failures++; $display("FAIL count_to_7: q1=%h want 7", q1); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (q1 !== 4'd0) begin failures++; $display("FAIL async_reset: q1=%h want 0", q1); end
    en1 = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_step_hold();
    en1 = 1'b1;
    step();
    checks++;
    if (q1 !== 4'd1) begin failures++; $display("FAIL single_step: q1=%h want 1", q1); end
    en1 = 1'b0;
    repeat (2) begin
      step();
      checks++;
      if (q1 !== 4'd1) begin failures++; $display("FAIL hold: q1=%h want 1", q1); end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (q1 !== 4'd0) begin failures++; $display("FAIL reset_then_hold: q1=%h want 0", q1); end
  endtask

  task automatic test_free_run();
    int pulses = 0;
    en1 = 1'b1;
    repeat (30) begin
      checks++;
      if (tc1 !== (m1 == 9)) begin failures++; $display("FAIL free_tc: tc1=%b q1=%h model=%0d", tc1, q1, m1); end
      if (tc1 === 1'b1) pulses++;
      step();
      checks++;
      if (q1 !== 4'(m1)) begin failures++; $display("FAIL free_q: q1=%h want %0d", q1, m1); end
    end
    checks++;
    if (pulses != 3 || q1 !== 4'd0) begin
      failures++;
      $display("FAIL free_summary: pulses=%0d q1=%h want 3 pulses and 0", pulses, q1);
    end
  endtask

  task automatic test_tc_gate();
    en1 = 1'b1;
    repeat (9) step();
    en1 = 1'b0;
    #1;
    checks++;
    if (tc1 !== 1'b0) begin failures++; $display("FAIL tc_gated: tc1=%b want 0", tc1); end
    step();
    checks++;
    if (q1 !== 4'd9) begin failures++; $display("FAIL hold_at_9: q1=%h want 9", q1); end
    en1 = 1'b1;
    #1;
    checks++;
    if (tc1 !== 1'b1) begin failures++; $display("FAIL tc_reenable: tc1=%b want 1", tc1); end
    step();
    checks++;
    if (q1 !== 4'd0) begin failures++; $display("FAIL wrap_9_0: q1=%h want 0", q1); end
    en1 = 1'b0;
  endtask

  task automatic test_multi();
    reset = 1'b1;
    step();
    reset = 1'b0;
    en2 = 1'b1;
    repeat (100) begin
      checks++;
      if (tc2 !== (m2 == 99)) begin failures++; $display("FAIL multi_tc: tc2=%b q2=%h model=%0d", tc2, q2, m2); end
      step();
      checks++;
      if (q2 !== bcd2(m2) || q2[3:0] > 4'd9 || q2[7:4] > 4'd9) begin
        failures++;
        $display("FAIL multi_q: q2=%h want %h", q2, bcd2(m2));
      end
    end
    checks++;
    if (q2 !== 8'h00) begin failures++; $display("FAIL multi_end: q2=%h want 00", q2); end
  endtask

  task automatic test_random();
    repeat (300) begin
      en1 = 1'($urandom);
      en2 = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (tc1 !== (en1 && m1 == 9) || tc2 !== (en2 && m2 == 99)) begin
        failures++;
        $display("FAIL rand_tc: tc1=%b tc2=%b models=%0d,%0d en=%b%b", tc1, tc2, m1, m2, en1, en2);
      end
      step();
      checks++;
      if (q1 !== 4'(m1) || q2 !== bcd2(m2)) begin
        failures++;
        $display("FAIL rand_q: q1=%h q2=%h want %0d %h", q1, q2, m1, bcd2(m2));
      end
    end
    en1 = 1'b0; en2 = 1'b0;
  endtask

  task automatic test_recover();
    logic [3:0] d1;
    d1 = 4'(m2 / 10);
    force dut2.Q = {d1, 4'hC};
    force dut1.Q = 4'hF;
    #1;
    release dut2.Q;
    release dut1.Q;
    en1 = 1'b1; en2 = 1'b1;
    #1;
    checks++;
    if (tc1 !== 1'b0 || tc2 !== 1'b0) begin failures++; $display("FAIL illegal_tc: tc1=%b tc2=%b want 0 0", tc1, tc2); end
    @(posedge clk);
    #1;
    checks++;
    if (q2 !== {d1, 4'h0}) begin failures++; $display("FAIL recover2: q2=%h want %h", q2, {d1, 4'h0}); end
    checks++;
    if (q1 !== 4'd0) begin failures++; $display("FAIL recover1: q1=%h want 0", q1); end
    m1 = 0;
    m2 = int'(d1) * 10;
    step();
    checks++;
    if (q1 !== 4'(m1) || q2 !== bcd2(m2)) begin
      failures++;
      $display("FAIL post_recover: q1=%h q2=%h want %0d %h", q1, q2, m1, bcd2(m2));
    end
    en1 = 1'b0; en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step_hold();
    test_free_run();
    test_tc_gate();
    test_multi();
    test_random();
    test_recover();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
